// File: rtl/cpu_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_muldiv_if
// Brief    : Issue/result bundle between the execute stage and the
//            multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] rt_i;
    logic             read_hilo_i;
    logic             abort_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;

    modport master (
        output start_i, op_i, rs_i, rt_i, read_hilo_i, abort_i,
        input  hi_o, lo_o, busy_o, stall_o, done_o
    );

    modport slave (
        input  start_i, op_i, rs_i, rt_i, read_hilo_i, abort_i,
        output hi_o, lo_o, busy_o, stall_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/cpu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_muldiv_unit
// Brief    : Multi-cycle multiply / radix-2 restoring divide unit owning the
//            HI/LO pair. Define CPU_MULDIV_MADD_EN to enable MADD/MSUB.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_muldiv_unit #(
    parameter int WIDTH        = 32,
    parameter int MULT_LATENCY = 2
) (
    input  wire logic   clk,
    input  wire logic   reset,
    cpu_muldiv_if.slave bus
);
    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
    localparam logic [2:0] c_OP_MADD  = 3'd6;
    localparam logic [2:0] c_OP_MSUB  = 3'd7;
    localparam int         c_CNT_W    = $clog2(WIDTH + MULT_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [2:0]         r_op;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_done;

    logic w_accept;
    logic w_is_mul;
    logic w_is_div;
    logic w_mul_wb;
    logic w_div_wb;

    // ------------------------------------------------------------------
    // Issue decode
    // ------------------------------------------------------------------
    assign w_accept = (r_state == S_IDLE) && bus.start_i && !bus.abort_i;

    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        case (bus.op_i)
            c_OP_MULT, c_OP_MULTU: w_is_mul = 1'b1;
            c_OP_DIV,  c_OP_DIVU:  w_is_div = 1'b1;
            c_OP_MADD, c_OP_MSUB:
`ifdef CPU_MULDIV_MADD_EN
                w_is_mul = 1'b1;
`else
                w_is_mul = 1'b0;
`endif
            default: w_is_mul = 1'b0;
        endcase
    end

    // Divider works on magnitudes; signs are restored in FIX from r_a/r_b.
    logic             w_sdiv_in;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;

    assign w_sdiv_in = (bus.op_i == c_OP_DIV);
    assign w_rs_mag  = (w_sdiv_in && bus.rs_i[WIDTH-1]) ? -bus.rs_i : bus.rs_i;
    assign w_rt_mag  = (w_sdiv_in && bus.rt_i[WIDTH-1]) ? -bus.rt_i : bus.rt_i;

    // ------------------------------------------------------------------
    // Multiplier (full 2*WIDTH product of sign- or zero-extended operands)
    // ------------------------------------------------------------------
    logic               w_mul_sgn;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;

    assign w_mul_sgn = (r_op != c_OP_MULTU);
    assign w_ext_a   = {{WIDTH{w_mul_sgn & r_a[WIDTH-1]}}, r_a};
    assign w_ext_b   = {{WIDTH{w_mul_sgn & r_b[WIDTH-1]}}, r_b};
    assign w_prod    = w_ext_a * w_ext_b;

`ifdef CPU_MULDIV_MADD_EN
    always_comb begin
        w_mul_res = w_prod;
        if (r_op == c_OP_MADD)
            w_mul_res = {r_hi, r_lo} + w_prod;
        else if (r_op == c_OP_MSUB)
            w_mul_res = {r_hi, r_lo} - w_prod;
    end
`else
    assign w_mul_res = w_prod;
`endif

    // ------------------------------------------------------------------
    // Restoring divide step and final sign correction
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic             w_sdiv;
    logic             w_q_neg;
    logic             w_r_neg;
    logic [WIDTH-1:0] w_div_lo;
    logic [WIDTH-1:0] w_div_hi;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[WIDTH-1:0] - r_div;

    assign w_sdiv  = (r_op == c_OP_DIV);
    assign w_q_neg = w_sdiv && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_r_neg = w_sdiv && r_a[WIDTH-1];

    always_comb begin
        w_div_lo = w_q_neg ? -r_quo : r_quo;
        w_div_hi = w_r_neg ? -r_rem : r_rem;
        if (r_b == '0) begin
            w_div_lo = '1;
            w_div_hi = r_a;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_mul_wb = 1'b0;
        w_div_wb = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul)
                    w_next = S_MUL;
                else if (w_accept && w_is_div)
                    w_next = S_DIV;
            end
            S_MUL: begin
                if (bus.abort_i) begin
                    w_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_next   = S_IDLE;
                    w_mul_wb = 1'b1;
                end
            end
            S_DIV: begin
                if (bus.abort_i)
                    w_next = S_IDLE;
                else if (r_cnt == '0)
                    w_next = S_FIX;
            end
            S_FIX: begin
                w_next   = S_IDLE;
                w_div_wb = !bus.abort_i;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_op   <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_mul_wb | w_div_wb;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.op_i;
                        r_a   <= bus.rs_i;
                        r_b   <= bus.rt_i;
                        r_rem <= '0;
                        r_quo <= w_rs_mag;
                        r_div <= w_rt_mag;
                        r_cnt <= w_is_div ? c_CNT_W'(WIDTH - 1) : c_CNT_W'(MULT_LATENCY - 1);
                        if (bus.op_i == c_OP_MTHI)
                            r_hi <= bus.rs_i;
                        if (bus.op_i == c_OP_MTLO)
                            r_lo <= bus.rs_i;
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (w_mul_wb)
                        {r_hi, r_lo} <= w_mul_res;
                end
                S_DIV: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                end
                S_FIX: begin
                    if (w_div_wb) begin
                        r_hi <= w_div_hi;
                        r_lo <= w_div_lo;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;
    assign bus.busy_o  = (r_state != S_IDLE);
    assign bus.stall_o = bus.busy_o & (bus.start_i | bus.read_hilo_i);
    assign bus.done_o  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_cpu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_muldiv_unit
// Brief    : Self-checking bench for cpu_muldiv_unit against an arithmetic
//            reference model (honours CPU_MULDIV_MADD_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_muldiv_unit;
    localparam int W   = 32;
    localparam int LAT = 2;
`ifdef CPU_MULDIV_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    cpu_muldiv_if #(.WIDTH(W)) bus ();

    cpu_muldiv_unit #(.WIDTH(W), .MULT_LATENCY(LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Architectural result of one op as {HI, LO}.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV:   return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            OP_MTHI:  return {a, lo};
            OP_MTLO:  return {hi, a};
            OP_MADD:  return MADD_EN ? ({hi, lo} + 64'(sa * sb)) : {hi, lo};
            default:  return MADD_EN ? ({hi, lo} - 64'(sa * sb)) : {hi, lo};
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op);
        case (op)
            OP_MULT, OP_MULTU: return LAT;
            OP_DIV, OP_DIVU:   return W + 1;
            OP_MADD, OP_MSUB:  return MADD_EN ? LAT : 0;
            default:           return 0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, scramble operands after accept, and measure busy window and done pulses.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int dones);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs_i    = a;
        bus.rt_i    = b;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.op_i    = 3'($urandom);
        bus.rs_i    = $urandom;
        bus.rt_i    = $urandom;
        lat   = -1;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done_o) dones++;
            if (!bus.busy_o) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (bus.done_o) dones++;
    endtask

    task automatic test_reset;
        bus.start_i     = 1'b1;
        bus.read_hilo_i = 1'b1;
        #1;
        checks++;
        if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state hi=%h lo=%h busy=%b done=%b expected all zero",
                     bus.hi_o, bus.lo_o, bus.busy_o, bus.done_o);
        end
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b expected=0", bus.stall_o);
        end
        bus.start_i     = 1'b0;
        bus.read_hilo_i = 1'b0;
    endtask

    task automatic test_move;
        int lat, dones;
        do_op(OP_MTHI, 32'h1234_5678, 32'h0, lat, dones);
        checks++;
        if (lat !== 0 || dones !== 0) begin
            failures++;
            $display("FAIL mthi_timing busy_cycles=%0d dones=%0d expected 0/0", lat, dones);
        end
        do_op(OP_MTLO, 32'h9ABC_DEF0, 32'h0, lat, dones);
        checks++;
        if (bus.hi_o !== 32'h1234_5678 || bus.lo_o !== 32'h9ABC_DEF0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL mt_values hi=%h lo=%h busy=%b expected 12345678/9abcdef0/0",
                     bus.hi_o, bus.lo_o, bus.busy_o);
        end
    endtask

    task automatic test_mult;
        int lat, dones;
        do_op(OP_MULT, 32'hFFFF_FFFE, 32'h3, lat, dones);
        checks++;
        if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFFA || lat !== LAT || dones !== 1) begin
            failures++;
            $display("FAIL mult_directed hi=%h lo=%h lat=%0d dones=%0d expected ffffffff/fffffffa/%0d/1",
                     bus.hi_o, bus.lo_o, lat, dones, LAT);
        end
        do_op(OP_MULTU, 32'hFFFF_FFFE, 32'h3, lat, dones);
        checks++;
        if (bus.hi_o !== 32'h0000_0002 || bus.lo_o !== 32'hFFFF_FFFA || lat !== LAT || dones !== 1) begin
            failures++;
            $display("FAIL multu_directed hi=%h lo=%h lat=%0d dones=%0d expected 00000002/fffffffa/%0d/1",
                     bus.hi_o, bus.lo_o, lat, dones, LAT);
        end
    endtask

    task automatic test_div;
        int lat, dones;
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, lat, dones);
        checks++;
        if (bus.lo_o !== 32'hFFFF_FFFD || bus.hi_o !== 32'hFFFF_FFFF || lat !== W + 1 || dones !== 1) begin
            failures++;
            $display("FAIL div_directed hi=%h lo=%h lat=%0d dones=%0d expected ffffffff/fffffffd/%0d/1",
                     bus.hi_o, bus.lo_o, lat, dones, W + 1);
        end
        do_op(OP_DIVU, 32'h7, 32'h0, lat, dones);
        checks++;
        if (bus.lo_o !== 32'hFFFF_FFFF || bus.hi_o !== 32'h7 || lat !== W + 1) begin
            failures++;
            $display("FAIL divu_by_zero hi=%h lo=%h lat=%0d expected 00000007/ffffffff/%0d",
                     bus.hi_o, bus.lo_o, lat, W + 1);
        end
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, dones);
        checks++;
        if (bus.lo_o !== 32'h8000_0000 || bus.hi_o !== 32'h0) begin
            failures++;
            $display("FAIL div_overflow hi=%h lo=%h expected 00000000/80000000", bus.hi_o, bus.lo_o);
        end
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'h0, lat, dones);
        checks++;
        if (bus.lo_o !== 32'hFFFF_FFFF || bus.hi_o !== 32'hFFFF_FFF9) begin
            failures++;
            $display("FAIL div_signed_by_zero hi=%h lo=%h expected fffffff9/ffffffff", bus.hi_o, bus.lo_o);
        end
    endtask

    task automatic test_stall_back_to_back;
        logic [31:0] a, b, c, d, e;
        logic [63:0] exp;
        int cyc, nostall;
        a = $urandom;
        b = 32'($urandom_range(1, 5000));
        c = $urandom;
        d = $urandom;
        e = $urandom;
        bus.read_hilo_i = 1'b1;
        bus.start_i     = 1'b1;
        bus.op_i        = OP_DIVU;
        bus.rs_i        = a;
        bus.rt_i        = b;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        cyc     = 0;
        nostall = 0;
        while (bus.busy_o && cyc < 100) begin
            if (cyc == 5) begin
                bus.start_i = 1'b1;
                bus.op_i    = OP_MULTU;
                bus.rs_i    = c;
                bus.rt_i    = d;
            end
            if (bus.stall_o !== 1'b1) nostall++;
            cyc++;
            @(posedge clk); #1;
        end
        checks++;
        if (cyc !== W + 1 || nostall !== 0) begin
            failures++;
            $display("FAIL div_stall busy_cycles=%0d unstalled=%0d expected %0d/0", cyc, nostall, W + 1);
        end
        exp = ref_op(OP_DIVU, a, b, 32'h0, 32'h0);
        checks++;
        if ({bus.hi_o, bus.lo_o} !== exp || bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL div_result_held_issue hi=%h lo=%h stall=%b expected %h/%h/0",
                     bus.hi_o, bus.lo_o, bus.stall_o, exp[63:32], exp[31:0]);
        end
        @(posedge clk); #1;
        bus.read_hilo_i = 1'b0;
        bus.op_i        = OP_MTLO;
        bus.rs_i        = e;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back_accept busy=%b expected 1", bus.busy_o);
        end
        cyc     = 0;
        nostall = 0;
        while (bus.busy_o && cyc < 100) begin
            if (bus.stall_o !== 1'b1) nostall++;
            cyc++;
            @(posedge clk); #1;
        end
        exp = ref_op(OP_MULTU, c, d, 32'h0, 32'h0);
        checks++;
        if ({bus.hi_o, bus.lo_o} !== exp || cyc !== LAT || nostall !== 0) begin
            failures++;
            $display("FAIL back_to_back_mult hi=%h lo=%h busy_cycles=%0d unstalled=%0d expected %h/%h/%0d/0",
                     bus.hi_o, bus.lo_o, cyc, nostall, exp[63:32], exp[31:0], LAT);
        end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        checks++;
        if (bus.lo_o !== e || bus.hi_o !== exp[63:32] || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL held_mtlo hi=%h lo=%h busy=%b expected %h/%h/0",
                     bus.hi_o, bus.lo_o, bus.busy_o, exp[63:32], e);
        end
    endtask

    task automatic test_abort;
        int lat, dones;
        do_op(OP_MTHI, 32'h55, 32'h0, lat, dones);
        do_op(OP_MTLO, 32'h55, 32'h0, lat, dones);
        bus.start_i = 1'b1;
        bus.op_i    = OP_DIV;
        bus.rs_i    = $urandom;
        bus.rt_i    = 32'($urandom_range(1, 100));
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        bus.abort_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.hi_o !== 32'h55 || bus.lo_o !== 32'h55) begin
            failures++;
            $display("FAIL abort_div busy=%b hi=%h lo=%h expected 0/55/55", bus.busy_o, bus.hi_o, bus.lo_o);
        end
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done_o) dones++;
        end
        checks++;
        if (dones !== 0 || bus.hi_o !== 32'h55 || bus.lo_o !== 32'h55) begin
            failures++;
            $display("FAIL abort_no_done dones=%0d hi=%h lo=%h expected 0/55/55", dones, bus.hi_o, bus.lo_o);
        end
        bus.abort_i = 1'b1;
        bus.start_i = 1'b1;
        bus.op_i    = OP_MTHI;
        bus.rs_i    = 32'hAAAA;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        checks++;
        if (bus.hi_o !== 32'h55 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_with_start hi=%h busy=%b expected 55/0", bus.hi_o, bus.busy_o);
        end
    endtask

    task automatic test_reset_mid;
        int lat, dones;
        do_op(OP_MTHI, 32'h1234, 32'h0, lat, dones);
        bus.start_i = 1'b1;
        bus.op_i    = OP_MULT;
        bus.rs_i    = $urandom | 32'h1;
        bus.rt_i    = $urandom | 32'h1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_mult hi=%h lo=%h busy=%b done=%b expected all zero",
                     bus.hi_o, bus.lo_o, bus.busy_o, bus.done_o);
        end
        #1 reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0 || bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_leftover hi=%h lo=%h done=%b expected 0/0/0", bus.hi_o, bus.lo_o, bus.done_o);
        end
    endtask

    task automatic test_madd;
        int lat, dones;
        logic [63:0] exp;
        do_op(OP_MTHI, 32'h0, 32'h0, lat, dones);
        do_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0, lat, dones);
        do_op(OP_MADD, 32'h1, 32'h1, lat, dones);
        exp = MADD_EN ? 64'h0000_0001_0000_0000 : 64'h0000_0000_FFFF_FFFF;
        checks++;
        if ({bus.hi_o, bus.lo_o} !== exp || lat !== ref_lat(OP_MADD) || dones !== (MADD_EN ? 1 : 0)) begin
            failures++;
            $display("FAIL madd_carry hi=%h lo=%h lat=%0d dones=%0d expected %h/%h/%0d",
                     bus.hi_o, bus.lo_o, lat, dones, exp[63:32], exp[31:0], ref_lat(OP_MADD));
        end
    endtask

    task automatic test_random;
        int lat, dones;
        logic [31:0] m_hi, m_lo, a, b;
        logic [2:0]  op;
        logic [63:0] exp;
        m_hi = $urandom;
        m_lo = $urandom;
        do_op(OP_MTHI, m_hi, 32'h0, lat, dones);
        do_op(OP_MTLO, m_lo, 32'h0, lat, dones);
        for (int n = 0; n < 30; n++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            exp = ref_op(op, a, b, m_hi, m_lo);
            do_op(op, a, b, lat, dones);
            checks++;
            if ({bus.hi_o, bus.lo_o} !== exp || lat !== ref_lat(op) || dones !== (ref_lat(op) > 0 ? 1 : 0)) begin
                failures++;
                $display("FAIL random_op op=%0d rs=%h rt=%h hi=%h lo=%h lat=%0d dones=%0d expected %h/%h/%0d",
                         op, a, b, bus.hi_o, bus.lo_o, lat, dones, exp[63:32], exp[31:0], ref_lat(op));
            end
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.start_i     = 1'b0;
        bus.op_i        = 3'd0;
        bus.rs_i        = 32'd0;
        bus.rt_i        = 32'd0;
        bus.read_hilo_i = 1'b0;
        bus.abort_i     = 1'b0;
        #12;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_move();
        test_mult();
        test_div();
        test_stall_back_to_back();
        test_abort();
        test_reset_mid();
        test_madd();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
